// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: single-outstanding sequencer between the execute stage
// and the shared multi-cycle multiplier/divider. Latches one request, pulses
// the unit's start control, stalls the pipeline until the result arrives and
// holds one writeback (result or $rstatus exception code) until acknowledged.
// Optional feature macro: MD_TIMEOUT_EN enables a WAIT watchdog that aborts
// after TIMEOUT_CYCLES and raises a sticky timeout flag.
module multdiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_result_rdy,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ack,
    output logic        timeout
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    localparam logic [4:0] RSTATUS_RD = 5'd30;

    state_t      state, state_nxt;
    logic        is_div_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q, b_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
    logic [31:0] exc_code;
    logic        accept, capture, expire;

    // A squashed instruction is never accepted; a flush in WAIT beats a ready
    assign accept   = (state == S_IDLE) & issue_valid & ~flush;
    assign capture  = (state == S_WAIT) & ~flush & md_result_rdy;
    assign exc_code = is_div_q ? 32'd5 : 32'd4;

`ifdef MD_TIMEOUT_EN
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt;
    logic       timeout_q;

    // Ready on the limit cycle wins, so expiry needs md_result_rdy low
    assign expire  = (state == S_WAIT) & ~flush & ~md_result_rdy & (wait_cnt == CNT_LAST);
    assign timeout = timeout_q;

    // Watchdog: counter restarts on WAIT entry, flag is sticky until reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_START)
                wait_cnt <= 8'd0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 8'd1;
            if (expire)
                timeout_q <= 1'b1;
        end
    end
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (!reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: state_nxt = flush ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (flush)
                    state_nxt = S_IDLE;
                else if (capture || expire)
                    state_nxt = S_DONE;
            end
            S_DONE:  if (wb_ack) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch and writeback capture; later issue_* changes are ignored
    always_ff @(posedge clock) begin
        if (!reset) begin
            is_div_q  <= 1'b0;
            rd_q      <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 32'd0;
        end else begin
            if (accept) begin
                is_div_q <= issue_is_div;
                rd_q     <= issue_rd;
                a_q      <= issue_a;
                b_q      <= issue_b;
            end
            if (capture) begin
                wb_rd_q   <= md_exception ? RSTATUS_RD : rd_q;
                wb_data_q <= md_exception ? exc_code : md_result;
            end else if (expire) begin
                wb_rd_q   <= RSTATUS_RD;
                wb_data_q <= exc_code;
            end
        end
    end

    // Outputs: stall releases in the ack cycle so a back-to-back issue can land
    always_comb begin
        stall        = (issue_valid & ~flush & ~((state == S_DONE) & wb_ack))
                       | (state == S_START) | (state == S_WAIT);
        busy         = (state != S_IDLE);
        md_ctrl_mult = (state == S_START) & ~is_div_q;
        md_ctrl_div  = (state == S_START) & is_div_q;
        wb_valid     = (state == S_DONE);
        wb_rd        = (state == S_DONE) ? wb_rd_q : 5'd0;
        wb_data      = (state == S_DONE) ? wb_data_q : 32'd0;
    end

    assign md_operand_a = a_q;
    assign md_operand_b = b_q;

endmodule
